data_selector_ctrl: RTL
=======================

// Module: data_selector_ctrl
// PURPOSE
//  Configuration sequencer for data_selector. Holds a shadow and an active table of
//  SELECTOR_ENTRIES select entries. Drives the selector's wSelec bus from the active
//  table and frames selector activity with wBusy. Shadow-to-active copy happens only at
//  frame boundaries, so a running frame always sees one consistent table.
// PARAMETERS
//  MAIN_INPUTS      16  valid main-bus nibble sources; main field must be < this
//  REGS_INPUTS      64  valid register nibble sources; regs field must be < this
//  SELECTOR_ENTRIES 16  number of select entries
//  MAIN_SEL_BITS     4  width of main field
//  REGS_SEL_BITS     6  width of regs field
//  FRAME_CYCLES      4  wBusy cycles per frame (>=1)
// PORTS
//  clk            in   1    clock, all logic on posedge
//  rst            in   1    synchronous reset, active-high
//  cfg_wr         in   1    write cfg_entry into shadow[cfg_idx]
//  cfg_idx        in   5    shadow entry index
//  cfg_entry      in   11   {regs[5:0], main[3:0], origin}; origin=1 selects regs source
//  cfg_commit     in   1    request shadow->active copy at next frame boundary
//  start          in   1    request one frame
//  wBusy          out  1    high during every RUN cycle
//  wSelec         out  176  active table; entry i at [11i+10:11i]
//  commit_pending out  1    commit requested, copy not yet done
//  frame_done     out  1    1-cycle pulse in the first cycle after a frame's last RUN cycle
//  cfg_err        out  1    1-cycle pulse in the cycle after a rejected write
// BEHAVIOUR
//  - Reset: shadow=active=0, wSelec=0, wBusy=0, commit_pending=0, frame_done=0,
//    cfg_err=0, state IDLE, cnt=0. Reset mid-frame aborts the frame and drops any pending
//    commit. Outputs show reset values from the cycle after the reset edge.
//  - Write: accepted on any edge, in any state. Rejected (shadow unchanged, cfg_err pulse)
//    if cfg_idx >= SELECTOR_ENTRIES, or origin=0 && main >= MAIN_INPUTS, or
//    origin=1 && regs >= REGS_INPUTS. Unused field of an entry is not checked.
//  - Commit: cfg_commit sets commit_pending on that edge. Swap edge = an edge in IDLE, or
//    the edge ending the last RUN cycle. At a swap edge with pending=1:
//    active<=shadow (pre-edge values), and pending is cleared unless cfg_commit is high in
//    the same cycle, in which case it stays 1. A cfg_wr on the swap edge does not reach
//    active until a later commit.
//  - wSelec is registered directly from active. It changes only at swap edges.
//  - FSM IDLE->RUN on start in IDLE. The swap is applied on the same edge, so the frame
//    uses the new table. cnt=0, wBusy=1 from the next cycle.
//  - RUN: cnt++ each cycle. At cnt==FRAME_CYCLES-1: swap edge, frame_done pulses next
//    cycle, then RUN->IDLE. If start is high in that last cycle, the FSM stays in RUN with
//    cnt=0 (back-to-back frames, no idle gap, frame_done still pulses). Start in any other
//    RUN cycle is ignored, not queued.
//  - Latency: wBusy rises 1 cycle after start; commit is visible on wSelec 2 edges after
//    cfg_commit when IDLE.
// STRUCTURE
//  - Shared include rtl/data_selector_defs.v holds ENTRY_BITS, field offsets
//    (ORIGIN=0, MAIN=1..4, REGS=5..10) and FSM state encodings; data_selector uses the
//    same field offsets.
//  - One combinational sub-module, selec_entry_check (entry+idx -> valid), instantiated
//    once. FSM, counter and tables stay in this module.
// TESTING
//  1 rst high for 2 cycles then low -> wSelec==0, wBusy==0, commit_pending==0, no pulses.
//  2 IDLE: write idx 3 = 11'h7A7 (regs 61, main 3, origin 1), no commit ->
//    wSelec[43:33]==0. Then cfg_commit -> pending=1 for 1 cycle, wSelec[43:33]==11'h7A7.
//  3 start 1 cycle -> wBusy high exactly 4 cycles, frame_done one pulse after.
//    start pulsed at RUN cnt=1 -> ignored. start at cnt=3 -> 8 contiguous busy cycles.
//  4 write idx 0 = 11'h001 + commit at RUN cnt=1 -> wSelec[10:0] unchanged through
//    cnt=3, updates on the edge wBusy falls, pending then 0.
//  5 cfg_idx=5'd16 -> cfg_err pulse, table unchanged. With MAIN_INPUTS=12, entry
//    origin=0 main=4'hC -> cfg_err, rejected; origin=1 main=4'hC regs=6'd5 -> accepted.
//  6 commit pending, rst at RUN cnt=2 -> next cycle wBusy=0, pending=0, wSelec=0,
//    no frame_done.

Source files
------------

// File: rtl/data_selector_ctrl_pkg.sv
// Package for data_selector_ctrl: entry field offsets and FSM state type,
// built from the shared data_selector definitions.
`include "data_selector_defs.v"

package data_selector_ctrl_pkg;
  localparam int ORIGIN_BIT = `DS_ORIGIN_BIT;
  localparam int MAIN_LSB   = `DS_MAIN_LSB;
  localparam int REGS_LSB   = `DS_REGS_LSB;

  typedef enum logic {
    ST_IDLE = `DS_ST_IDLE,
    ST_RUN  = `DS_ST_RUN
  } state_t;
endpackage

// File: rtl/data_selector_defs.v
// Shared layout and state-encoding definitions for the data_selector family.
// Entry layout (ENTRY_BITS = 11):
//   [0]     origin  : 1 selects the register source, 0 the main-bus source
//   [4:1]   main    : main-bus nibble source index
//   [10:5]  regs    : register nibble source index
// data_selector decodes wSelec with the same field offsets.
`ifndef DATA_SELECTOR_DEFS_V
`define DATA_SELECTOR_DEFS_V
`define DS_ENTRY_BITS 11
`define DS_ORIGIN_BIT 0
`define DS_MAIN_LSB   1
`define DS_MAIN_MSB   4
`define DS_REGS_LSB   5
`define DS_REGS_MSB   10
`define DS_ST_IDLE    1'b0
`define DS_ST_RUN     1'b1
`endif

// File: rtl/selec_entry_check.sv
// Combinational validity check for a configuration write.
// Ports:
//   entry : candidate select entry {regs, main, origin}
//   idx   : target shadow index
//   valid : 1 when idx is in range and the field chosen by origin is in range
// The field not selected by origin is deliberately ignored.
module selec_entry_check
  import data_selector_ctrl_pkg::*;
#(
  parameter int MAIN_INPUTS      = 16,
  parameter int REGS_INPUTS      = 64,
  parameter int SELECTOR_ENTRIES = 16,
  parameter int MAIN_SEL_BITS    = 4,
  parameter int REGS_SEL_BITS    = 6
) (
  input  logic [MAIN_SEL_BITS+REGS_SEL_BITS:0] entry,
  input  logic [4:0]                           idx,
  output logic                                 valid
);
  logic                     origin;
  logic [MAIN_SEL_BITS-1:0] main_f;
  logic [REGS_SEL_BITS-1:0] regs_f;
  logic                     idx_ok;
  logic                     src_ok;

  assign origin = entry[ORIGIN_BIT];
  assign main_f = entry[MAIN_LSB +: MAIN_SEL_BITS];
  assign regs_f = entry[REGS_LSB +: REGS_SEL_BITS];

  // Compare in 32 bits so source counts that do not fit the field width still work.
  assign idx_ok = 32'(idx) < SELECTOR_ENTRIES;
  assign src_ok = origin ? (32'(regs_f) < REGS_INPUTS) : (32'(main_f) < MAIN_INPUTS);
  assign valid  = idx_ok && src_ok;
endmodule

// File: rtl/data_selector_ctrl.sv
// Configuration sequencer for data_selector.
// Holds a shadow and an active select table. The active table drives wSelec;
// the shadow is copied into it only at frame boundaries (any IDLE edge, or the
// edge that ends the last RUN cycle), so a running frame sees one consistent table.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cfg_wr/idx/entry : write an entry into the shadow table (range-checked)
//   cfg_commit     : request shadow->active copy at the next boundary
//   start          : request one frame of FRAME_CYCLES busy cycles
//   wBusy          : high during every RUN cycle
//   wSelec         : active table, entry i at [EW*i +: EW]
//   commit_pending : commit requested but not yet applied
//   frame_done     : pulse in the cycle after a frame's last RUN cycle
//   cfg_err        : pulse in the cycle after a rejected write
module data_selector_ctrl
  import data_selector_ctrl_pkg::*;
#(
  parameter int MAIN_INPUTS      = 16,
  parameter int REGS_INPUTS      = 64,
  parameter int SELECTOR_ENTRIES = 16,
  parameter int MAIN_SEL_BITS    = 4,
  parameter int REGS_SEL_BITS    = 6,
  parameter int FRAME_CYCLES     = 4
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    cfg_wr,
  input  logic [4:0]                                              cfg_idx,
  input  logic [MAIN_SEL_BITS+REGS_SEL_BITS:0]                    cfg_entry,
  input  logic                                                    cfg_commit,
  input  logic                                                    start,
  output logic                                                    wBusy,
  output logic [SELECTOR_ENTRIES*(1+MAIN_SEL_BITS+REGS_SEL_BITS)-1:0] wSelec,
  output logic                                                    commit_pending,
  output logic                                                    frame_done,
  output logic                                                    cfg_err
);
  localparam int EW = 1 + MAIN_SEL_BITS + REGS_SEL_BITS;
  localparam int IW = (SELECTOR_ENTRIES > 1) ? $clog2(SELECTOR_ENTRIES) : 1;
  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);

  logic [EW-1:0] shadow [SELECTOR_ENTRIES];
  logic [EW-1:0] active [SELECTOR_ENTRIES];
  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_ok;
  logic          last_run;
  logic          swap;

  selec_entry_check #(
    .MAIN_INPUTS      (MAIN_INPUTS),
    .REGS_INPUTS      (REGS_INPUTS),
    .SELECTOR_ENTRIES (SELECTOR_ENTRIES),
    .MAIN_SEL_BITS    (MAIN_SEL_BITS),
    .REGS_SEL_BITS    (REGS_SEL_BITS)
  ) u_check (
    .entry (cfg_entry),
    .idx   (cfg_idx),
    .valid (wr_ok)
  );

  assign last_run = (state == ST_RUN) && (cnt == CNT_LAST);
  assign swap     = (state == ST_IDLE) || last_run;

  // Table storage. The swap reads the pre-edge shadow, so a write landing on
  // the same edge waits for a later commit. A commit arriving on the swap
  // edge itself re-arms pending for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SELECTOR_ENTRIES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pending <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !wr_ok;
      if (cfg_wr && wr_ok)
        shadow[cfg_idx[IW-1:0]] <= cfg_entry;
      if (swap && commit_pending) begin
        for (int i = 0; i < SELECTOR_ENTRIES; i++)
          active[i] <= shadow[i];
        commit_pending <= cfg_commit;
      end else if (cfg_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Frame FSM with registered wBusy / frame_done. A start seen in the last
  // RUN cycle chains straight into the next frame; elsewhere in RUN it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wBusy      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_run;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
            wBusy <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!start) begin
              state <= ST_IDLE;
              wBusy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          wBusy <= 1'b0;
        end
      endcase
    end
  end

  // wSelec is the active register table laid out flat.
  for (genvar g = 0; g < SELECTOR_ENTRIES; g++) begin : g_sel
    assign wSelec[g*EW +: EW] = active[g];
  end
endmodule
